// File: rtl/mem_responder.sv
// Word-addressed memory target with a fixed wait-state handshake: accept one request, wait,
// commit or read, pulse ACK. Optional range checking via `define MEM_RESPONDER_RANGE_CHECK_EN.
module mem_responder #(
   parameter int unsigned WAIT_CYCLES = 2,
   parameter int unsigned DEPTH_LOG2  = 10,
   parameter int unsigned ADDR_WIDTH  = 26,
   parameter int unsigned DATA_WIDTH  = 32
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_WIDTH-1:0] ADDR,
   input  logic [DATA_WIDTH-1:0] DATA_IN,
   output logic [DATA_WIDTH-1:0] DATA_OUT,
   output logic                  ACK,
   output logic                  BUSY,
   output logic                  ERR
);

   typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

   localparam logic [DATA_WIDTH-1:0] OorData = DATA_WIDTH'(32'hDEAD_BEEF);

   state_e                 state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [DEPTH_LOG2-1:0]  idx_q, idx_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic [DATA_WIDTH-1:0]  rdata_q, rdata_d;
   logic                   is_wr_q, is_wr_d;
   logic                   oor_q, oor_d;
   logic                   err_d;
   logic                   commit;
   logic                   mem_we;
   logic                   addr_oor;

   logic [DATA_WIDTH-1:0]  mem [2**DEPTH_LOG2];

`ifdef MEM_RESPONDER_RANGE_CHECK_EN
   logic err_q;

   assign addr_oor = |ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
   assign ERR      = err_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end
`else
   logic unused_addr_hi;
   logic unused_err;

   assign addr_oor       = 1'b0;
   assign unused_addr_hi = ^ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
   assign unused_err     = err_d;
   assign ERR            = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      is_wr_d = is_wr_q;
      oor_d   = oor_q;
      rdata_d = rdata_q;
      err_d   = 1'b0;
      commit  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (READ ^ WRITE) begin
               idx_d   = ADDR[DEPTH_LOG2-1:0];
               wdata_d = DATA_IN;
               is_wr_d = WRITE;
               oor_d   = addr_oor;
               cnt_d   = 4'(WAIT_CYCLES);
               if (WAIT_CYCLES == 0) begin
                  state_d = StDone;
                  commit  = 1'b1;
               end else begin
                  state_d = StWait;
               end
            end else if (READ && WRITE) begin
               err_d = 1'b1;
            end
         end
         StWait: begin
            if (cnt_q == 4'd1) begin
               state_d = StDone;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         StDone: state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // The _d copies equal the latched request in WAIT and the fresh one when WAIT_CYCLES is 0.
      if (commit) begin
         if (!is_wr_d) begin
            rdata_d = oor_d ? OorData : mem[idx_d];
         end
         err_d = oor_d;
      end
   end

   assign mem_we   = commit && is_wr_d && !oor_d && !RST;
   assign ACK      = (state_q == StDone);
   assign BUSY     = (state_q != StIdle);
   assign DATA_OUT = rdata_q;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= StIdle;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         is_wr_q <= 1'b0;
         oor_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         is_wr_q <= is_wr_d;
         oor_q   <= oor_d;
      end
   end

   // Storage has no reset; contents survive RST.
   always_ff @(posedge CLK) begin
      if (mem_we) begin
         mem[idx_d] <= wdata_d;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: directed requests push expected ACK responses,
// a negedge monitor pops and compares them.
module tb_mem_responder;

   localparam int unsigned WAIT = 2;
`ifdef MEM_RESPONDER_RANGE_CHECK_EN
   localparam bit RC = 1'b1;
`else
   localparam bit RC = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        rd;
   logic        wr;
   logic [25:0] addr;
   logic [31:0] din;
   logic [31:0] dout;
   logic        ack;
   logic        busy;
   logic        err;

   typedef struct {
      int unsigned cyc;
      logic [31:0] data;
      logic        err;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;

   mem_responder #(
      .WAIT_CYCLES(WAIT),
      .DEPTH_LOG2 (10),
      .ADDR_WIDTH (26),
      .DATA_WIDTH (32)
   ) dut (
      .CLK     (clk),
      .RST     (rst),
      .READ    (rd),
      .WRITE   (wr),
      .ADDR    (addr),
      .DATA_IN (din),
      .DATA_OUT(dout),
      .ACK     (ack),
      .BUSY    (busy),
      .ERR     (err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Monitor: every ACK must match the oldest outstanding expectation.
   exp_t mon_e;
   always @(negedge clk) begin
      if (ack === 1'b1) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack: got ACK=1 expected ACK=0 (cycle %0d)", cyc);
         end else begin
            mon_e = sb.pop_front();
            check("ack_cycle", cyc, mon_e.cyc);
            check("ack_data", dout, mon_e.data);
            check("ack_err", {31'd0, err}, {31'd0, mon_e.err});
         end
      end
   end

   task automatic push_exp(input int unsigned c, input logic [31:0] d, input logic e);
      exp_t x;
      x.cyc  = c;
      x.data = d;
      x.err  = e;
      sb.push_back(x);
   endtask

   // Issue one request, drop strobes after acceptance, and measure BUSY length.
   task automatic req(input logic r, input logic w, input logic [25:0] a, input logic [31:0] d,
                      input logic [31:0] exp_data, input logic exp_err);
      int n;
      @(negedge clk);
      rd   = r;
      wr   = w;
      addr = a;
      din  = d;
      push_exp(cyc + 1 + WAIT, exp_data, exp_err);
      @(negedge clk);
      rd   = 1'b0;
      wr   = 1'b0;
      addr = 26'h3FF_FFFF;
      din  = 32'hFFFF_FFFF;
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("busy_cycles", n, WAIT + 1);
      check("ack_seen", sb.size(), 0);
   endtask

   initial begin
      int n;
      rst  = 1'b1;
      rd   = 1'b0;
      wr   = 1'b0;
      addr = '0;
      din  = '0;
      repeat (3) @(negedge clk);
      check("reset_busy", {31'd0, busy}, 0);
      check("reset_ack", {31'd0, ack}, 0);
      check("reset_dout", dout, 0);
      check("reset_err", {31'd0, err}, 0);
      rst = 1'b0;

      // Write then read back; write completion leaves DATA_OUT at 0.
      req(1'b0, 1'b1, 26'h005, 32'h1234_5678, 32'h0, 1'b0);
      req(1'b1, 1'b0, 26'h005, 32'h0, 32'h1234_5678, 1'b0);
      @(negedge clk);
      check("dout_hold1", dout, 32'h1234_5678);
      @(negedge clk);
      check("dout_hold2", dout, 32'h1234_5678);

      // Both strobes: ignored, ERR pulse only with range checking.
      @(negedge clk);
      rd   = 1'b1;
      wr   = 1'b1;
      addr = 26'h005;
      din  = 32'hFFFF_FFFF;
      @(negedge clk);
      check("illegal_busy", {31'd0, busy}, 0);
      check("illegal_err", {31'd0, err}, {31'd0, RC});
      rd = 1'b0;
      wr = 1'b0;
      @(negedge clk);
      check("illegal_busy2", {31'd0, busy}, 0);
      check("illegal_err2", {31'd0, err}, 0);
      req(1'b1, 1'b0, 26'h005, 32'h0, 32'h1234_5678, 1'b0);

      // Reset during WAIT aborts the write to 0x3FF.
      req(1'b0, 1'b1, 26'h3FF, 32'h0BAD_F00D, 32'h1234_5678, 1'b0);
      @(negedge clk);
      wr   = 1'b1;
      addr = 26'h3FF;
      din  = 32'hA5A5_A5A5;
      @(negedge clk);
      wr = 1'b0;
      check("abort_busy_wait", {31'd0, busy}, 1);
      rst = 1'b1;
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 0);
      check("abort_ack", {31'd0, ack}, 0);
      check("abort_dout", dout, 0);
      rst = 1'b0;
      @(negedge clk);
      check("abort_ack2", {31'd0, ack}, 0);
      check("abort_busy2", {31'd0, busy}, 0);
      req(1'b1, 1'b0, 26'h3FF, 32'h0, 32'h0BAD_F00D, 1'b0);

      // Strobe held across ACK: second request accepted after DONE, ACK 4 cycles later.
      @(negedge clk);
      rd   = 1'b1;
      addr = 26'h3FF;
      push_exp(cyc + 1 + WAIT, 32'h0BAD_F00D, 1'b0);
      push_exp(cyc + 1 + WAIT + 4, 32'h0BAD_F00D, 1'b0);
      n = 0;
      while (!ack && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("held_first_ack", {31'd0, ack}, 1);
      @(negedge clk);
      check("held_idle_gap", {31'd0, busy}, 0);
      @(negedge clk);
      rd = 1'b0;
      check("held_reaccept", {31'd0, busy}, 1);
      n = 0;
      while (busy && n < 40) begin
         n++;
         @(negedge clk);
      end
      check("held_done", sb.size(), 0);

      // Aliasing versus range checking.
      req(1'b0, 1'b1, 26'h000, 32'hCAFE_0000, 32'h0BAD_F00D, 1'b0);
      req(1'b0, 1'b1, 26'h400, 32'h0000_0001, 32'h0BAD_F00D, RC);
      req(1'b1, 1'b0, 26'h000, 32'h0, RC ? 32'hCAFE_0000 : 32'h0000_0001, 1'b0);
      req(1'b1, 1'b0, 26'h400, 32'h0, RC ? 32'hDEAD_BEEF : 32'h0000_0001, RC);

      repeat (5) @(negedge clk);
      check("sb_empty", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
